// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fsm_pkg
// Description : State encoding for the flit transmitter control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } tx_state_e;

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/ni_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ni_pkg
// Description : Flit and packet definitions shared between the flit transmitter
//               and the network-interface side.
//               - req_packet_s  : head, body[TOTAL_FLITS-2], tail flits
//               - resp_packet_s : RESP_FLITS response flits, index 0 first
// Revision    : 1.0 - initial release
// ============================================================================
package ni_pkg;

    localparam int FLIT_W      = 16;
    localparam int TOTAL_FLITS = 4;
    localparam int RESP_FLITS  = 2;

    typedef struct packed {
        logic [FLIT_W-1:0]                   head_flit;
        logic [TOTAL_FLITS-3:0][FLIT_W-1:0]  body_flit;
        logic [FLIT_W-1:0]                   tail_flit;
    } req_packet_s;

    typedef struct packed {
        logic [RESP_FLITS-1:0][FLIT_W-1:0]   flit;
    } resp_packet_s;

endpackage : ni_pkg
`default_nettype wire

// File: rtl/flit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : flit_serializer
// Description : Latches a request packet and presents its flits one at a time
//               (head, body[0..], tail) with a valid/ready handshake toward the
//               NI. Flit and enable hold while the NI stalls.
// Ports       : clk, resetn      - clock, synchronous active-low reset
//               start            - latch packet and begin sending (IDLE accept)
//               packet           - request packet to serialise
//               ni_ready         - NI consumes the current flit this cycle
//               o_flit, enable   - registered flit and its valid
//               done             - tail flit consumed on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module flit_serializer
    import ni_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  req_packet_s       packet,
    input  logic              ni_ready,
    output logic [FLIT_W-1:0] o_flit,
    output logic              enable,
    output logic              done
);

    localparam int                IDX_W    = $clog2(TOTAL_FLITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TOTAL_FLITS - 1);

    logic [TOTAL_FLITS-1:0][FLIT_W-1:0] flat;
    logic [TOTAL_FLITS-1:0][FLIT_W-1:0] flits;
    logic [IDX_W-1:0]                   flit_idx;

    // Flatten the packet into send order so one index walks every flit.
    assign flat[0]             = packet.head_flit;
    assign flat[TOTAL_FLITS-1] = packet.tail_flit;
    generate
        for (genvar g = 0; g < TOTAL_FLITS - 2; g++) begin : g_body
            assign flat[g+1] = packet.body_flit[g];
        end
    endgenerate

    assign done = enable && ni_ready && (flit_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            flits    <= '0;
            flit_idx <= '0;
            o_flit   <= '0;
            enable   <= 1'b0;
        end else if (start) begin
            // Head goes out directly from the input so it appears next cycle.
            flits    <= flat;
            flit_idx <= '0;
            o_flit   <= packet.head_flit;
            enable   <= 1'b1;
        end else if (enable && ni_ready) begin
            if (flit_idx == LAST_IDX) begin
                enable <= 1'b0;
                o_flit <= '0;
            end else begin
                flit_idx <= flit_idx + 1'b1;
                o_flit   <= flits[flit_idx + 1'b1];
            end
        end
    end

endmodule : flit_serializer
`default_nettype wire

// File: rtl/noc_flit_tx.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_tx
// Description : Sends a request packet flit-by-flit to the NI, then collects
//               RESP_FLITS response flits, reporting completion or a timeout.
// Ports       : clk, resetn               - clock, synchronous active-low reset
//               req_valid/req_packet/req_ready - upstream request handshake
//               o_flit/enable/ni_ready    - flit stream toward the NI
//               i_flit/valid_in           - response flits from the NI
//               resp_valid/resp_packet/resp_err - response result (err=timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_tx
    import ni_pkg::*;
    import fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  req_packet_s       req_packet,
    output logic              req_ready,
    output logic [FLIT_W-1:0] o_flit,
    output logic              enable,
    input  logic              ni_ready,
    input  logic [FLIT_W-1:0] i_flit,
    input  logic              valid_in,
    output logic              resp_valid,
    output resp_packet_s      resp_packet,
    output logic              resp_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int RC_W = $clog2(RESP_FLITS + 1);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [RC_W-1:0]  resp_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             accept;
    logic             tx_done;
    logic             resp_last;
    logic             timeout_hit;

    assign accept      = (state == IDLE) && req_valid;
    assign resp_last   = (state == WAIT_RESP) && valid_in &&
                         (resp_cnt == RC_W'(RESP_FLITS - 1));
    // A response flit arriving on the terminal count takes priority.
    assign timeout_hit = (state == WAIT_RESP) && !valid_in &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    flit_serializer u_serializer (
        .clk      (clk),
        .resetn   (resetn),
        .start    (accept),
        .packet   (req_packet),
        .ni_ready (ni_ready),
        .o_flit   (o_flit),
        .enable   (enable),
        .done     (tx_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept)                   state_next = SEND;
            SEND:      if (tx_done)                  state_next = WAIT_RESP;
            WAIT_RESP: if (resp_last || timeout_hit) state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_packet <= '0;
            resp_cnt    <= '0;
            to_cnt      <= '0;
        end else begin
            req_ready  <= (state_next == IDLE);
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (tx_done) begin
                // Fresh collection window: a timed-out result then carries
                // only this transaction's flits.
                resp_cnt    <= '0;
                to_cnt      <= '0;
                resp_packet <= '0;
            end
            if (state == WAIT_RESP) begin
                if (valid_in) begin
                    for (int i = 0; i < RESP_FLITS; i++) begin
                        if (resp_cnt == RC_W'(i)) resp_packet.flit[i] <= i_flit;
                    end
                    resp_cnt <= resp_cnt + 1'b1;
                    to_cnt   <= '0;
                    if (resp_last) resp_valid <= 1'b1;
                end else if (timeout_hit) begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule : noc_flit_tx
`default_nettype wire

// File: tb/tb_noc_flit_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_flit_tx
// Description : Directed self-checking bench for noc_flit_tx (TIMEOUT_CYCLES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_flit_tx;
    import ni_pkg::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    req_packet_s       req_packet;
    logic              req_ready;
    logic [FLIT_W-1:0] o_flit;
    logic              enable;
    logic              ni_ready;
    logic [FLIT_W-1:0] i_flit;
    logic              valid_in;
    logic              resp_valid;
    resp_packet_s      resp_packet;
    logic              resp_err;

    int tests = 0;
    int fails = 0;

    noc_flit_tx #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_packet  (req_packet),
        .req_ready   (req_ready),
        .o_flit      (o_flit),
        .enable      (enable),
        .ni_ready    (ni_ready),
        .i_flit      (i_flit),
        .valid_in    (valid_in),
        .resp_valid  (resp_valid),
        .resp_packet (resp_packet),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [15:0] a, input logic [15:0] b);
        valid_in = 1'b1;
        i_flit   = a;
        tick();
        i_flit   = b;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        tests++;
        if (req_ready !== 1'b1 || enable !== 1'b0 || o_flit !== 16'h0 ||
            resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_packet !== '0) begin
            fails++;
            $display("FAIL reset: ready=%b en=%b flit=%h rv=%b err=%b pkt=%h, want 1 0 0000 0 0 0",
                     req_ready, enable, o_flit, resp_valid, resp_err, resp_packet);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_send_basic();
        logic [15:0] exp [4] = '{16'h8001, 16'h1234, 16'h5678, 16'hC0FF};
        ni_ready = 1'b1;
        accept();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (enable !== 1'b1 || o_flit !== exp[i] || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL send_flit%0d: en=%b flit=%h ready=%b, want 1 %h 0",
                         i, enable, o_flit, req_ready, exp[i]);
            end
            tick();
        end
        tests++;
        if (enable !== 1'b0 || o_flit !== 16'h0) begin
            fails++;
            $display("FAIL send_end: en=%b flit=%h, want 0 0000", enable, o_flit);
        end
        respond(16'hAAAA, 16'h5555);
        tests++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || req_ready !== 1'b1 ||
            resp_packet.flit[0] !== 16'hAAAA || resp_packet.flit[1] !== 16'h5555) begin
            fails++;
            $display("FAIL resp_ok: rv=%b err=%b ready=%b f0=%h f1=%h, want 1 0 1 aaaa 5555",
                     resp_valid, resp_err, req_ready, resp_packet.flit[0], resp_packet.flit[1]);
        end
        tick();
        tests++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL resp_pulse: rv=%b, want 0", resp_valid);
        end
    endtask

    task automatic test_backpressure_timeout();
        ni_ready = 1'b1;
        accept();
        tick();
        ni_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (enable !== 1'b1 || o_flit !== 16'h1234) begin
                fails++;
                $display("FAIL stall_hold%0d: en=%b flit=%h, want 1 1234", i, enable, o_flit);
            end
            if (i == 3) ni_ready = 1'b1;
            else        tick();
        end
        tick();
        tests++;
        if (enable !== 1'b1 || o_flit !== 16'h5678) begin
            fails++;
            $display("FAIL stall_body1: en=%b flit=%h, want 1 5678", enable, o_flit);
        end
        tick();
        tests++;
        if (enable !== 1'b1 || o_flit !== 16'hC0FF) begin
            fails++;
            $display("FAIL stall_tail: en=%b flit=%h, want 1 c0ff", enable, o_flit);
        end
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (k < 8 && resp_valid !== 1'b0) begin
                fails++;
                $display("FAIL timeout_early k=%0d: rv=%b, want 0", k, resp_valid);
            end else if (k == 8 && (resp_valid !== 1'b1 || resp_err !== 1'b1)) begin
                fails++;
                $display("FAIL timeout: rv=%b err=%b, want 1 1", resp_valid, resp_err);
            end
        end
        tick();
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL timeout_after: rv=%b ready=%b, want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_timeout_coincide();
        ni_ready = 1'b1;
        accept();
        for (int i = 0; i < 4; i++) tick();
        for (int k = 1; k <= 7; k++) tick();
        respond(16'hBEEF, 16'h0BAD);
        tests++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 ||
            resp_packet.flit[0] !== 16'hBEEF || resp_packet.flit[1] !== 16'h0BAD) begin
            fails++;
            $display("FAIL coincide: rv=%b err=%b f0=%h f1=%h, want 1 0 beef 0bad",
                     resp_valid, resp_err, resp_packet.flit[0], resp_packet.flit[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        ni_ready = 1'b1;
        accept();
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tests++;
        if (enable !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: en=%b rv=%b ready=%b, want 0 0 1", enable, resp_valid, req_ready);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (resp_valid === 1'b1 || enable === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_quiet: spurious rv/en=1, want 0");
        end
        accept();
        tests++;
        if (enable !== 1'b1 || o_flit !== 16'h8001) begin
            fails++;
            $display("FAIL reset_restart: en=%b flit=%h, want 1 8001", enable, o_flit);
        end
        for (int i = 0; i < 4; i++) tick();
        respond(16'h0F0F, 16'hF0F0);
        tests++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_restart_resp: rv=%b err=%b, want 1 0", resp_valid, resp_err);
        end
        tick();
    endtask

    task automatic test_ignore_valid_in();
        bit seen = 1'b0;
        valid_in = 1'b1;
        i_flit   = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        ni_ready = 1'b1;
        accept();
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) seen = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL ignore_rv: resp_valid=1 while idle/send, want 0");
        end
        respond(16'h1111, 16'h2222);
        tests++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 ||
            resp_packet.flit[0] !== 16'h1111 || resp_packet.flit[1] !== 16'h2222) begin
            fails++;
            $display("FAIL ignore_pkt: rv=%b err=%b f0=%h f1=%h, want 1 0 1111 2222",
                     resp_valid, resp_err, resp_packet.flit[0], resp_packet.flit[1]);
        end
        tick();
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        ni_ready  = 1'b0;
        valid_in  = 1'b0;
        i_flit    = '0;
        req_packet.head_flit    = 16'h8001;
        req_packet.body_flit[0] = 16'h1234;
        req_packet.body_flit[1] = 16'h5678;
        req_packet.tail_flit    = 16'hC0FF;

        test_reset();
        test_send_basic();
        test_backpressure_timeout();
        test_timeout_coincide();
        test_reset_mid();
        test_ignore_valid_in();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_noc_flit_tx
`default_nettype wire

// File: doc/noc_flit_tx.md
NOC_FLIT_TX -- requirements
Module: noc_flit_tx

Interface
REQ-001 Param TIMEOUT_CYCLES, default 256: response-wait cycles before a timeout error is declared.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  upstream request packet valid.
REQ-005 req_packet  input  req_packet_s  head_flit, body_flit[TOTAL_FLITS-2], tail_flit.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 o_flit  output  16  flit driven toward the NI receive port (NI i_flit).
REQ-008 enable  output  1  o_flit valid (drives NI enable).
REQ-009 ni_ready  input  1  NI accepts the current flit this cycle (NI ready).
REQ-010 i_flit  input  16  response flit from the NI (NI o_flit).
REQ-011 valid_in  input  1  i_flit valid (NI valid_out).
REQ-012 resp_valid  output  1  one-cycle pulse: response complete or timed out.
REQ-013 resp_packet  output  resp_packet_s  RESP_FLITS collected response flits, index 0 first.
REQ-014 resp_err  output  1  qualifies resp_valid; 1 = timeout.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, WAIT_RESP; all outputs registered.
REQ-016 IDLE: req_ready=1, enable=0; when req_valid=1 at an edge, the packet SHALL be latched, flit_idx=0, and the next state SHALL be SEND.
REQ-017 SEND: enable=1 and o_flit=flit[flit_idx]; flit order SHALL be head, body[0..TOTAL_FLITS-3], tail.
REQ-018 A flit SHALL be consumed on an edge where enable=1 and ni_ready=1; flit_idx SHALL then increment.
REQ-019 With ni_ready=0, o_flit and enable SHALL hold unchanged; there is no timeout in SEND.
REQ-020 Latency: head on o_flit the cycle after request acceptance; with ni_ready held 1, the packet SHALL take exactly TOTAL_FLITS consecutive cycles.
REQ-021 After the tail is consumed: enable=0, o_flit=0 on the next cycle, state WAIT_RESP, resp_cnt=0, timeout counter=0.
REQ-022 WAIT_RESP: each valid_in=1 edge SHALL store i_flit into resp_packet[resp_cnt], increment resp_cnt and clear the timeout counter.
REQ-023 On the edge storing flit RESP_FLITS-1, the block SHALL assert resp_valid=1, resp_err=0 for one cycle and return to IDLE.
REQ-024 If the timeout counter reaches TIMEOUT_CYCLES-1 without valid_in, the block SHALL assert resp_valid=1, resp_err=1 for one cycle, keep the partial resp_packet, and return to IDLE.
REQ-025 If valid_in and the timeout terminal count coincide, valid_in SHALL win (no error).
REQ-026 valid_in in IDLE or SEND SHALL be ignored.
REQ-027 req_ready=0 in SEND and WAIT_RESP; req_valid in those states SHALL be ignored.
REQ-028 Counter widths: flit_idx $clog2(TOTAL_FLITS), resp_cnt $clog2(RESP_FLITS+1), timeout $clog2(TIMEOUT_CYCLES); no wrap past terminal values.

Reset
REQ-029 resetn=0 at an edge SHALL force IDLE; req_ready=1; enable=0; o_flit=0; resp_valid=0; resp_err=0; resp_packet=0; all counters=0.
REQ-030 Reset mid-SEND or mid-WAIT_RESP SHALL abort the transaction with no resp_valid pulse; enable SHALL be 0 on the cycle after the reset edge.

Structure
REQ-031 ni_pkg SHALL hold TOTAL_FLITS, req_packet_s, the new RESP_FLITS constant, and resp_packet_s.
REQ-032 fsm_pkg SHALL hold the tx_state_e enum (IDLE, SEND, WAIT_RESP).
REQ-033 Sub-module flit_serializer (packet latch, flit_idx, ready/enable hold) is natural; response collection and timeout stay in noc_flit_tx.

Verification
REQ-034 Packet head 0x8001, body 0x1234/0x5678, tail 0xC0FF, ni_ready=1 -> enable high TOTAL_FLITS cycles; o_flit 0x8001, 0x1234, 0x5678, 0xC0FF on consecutive cycles.
REQ-035 Same packet, ni_ready=0 for 3 cycles during body[0] -> 0x1234 and enable held 3 extra cycles; no duplicated or lost flit.
REQ-036 After send, valid_in pulses carry 0xAAAA, 0x5555 (RESP_FLITS=2) -> one resp_valid, resp_err=0, resp_packet={0xAAAA,0x5555}, req_ready=1 next cycle.
REQ-037 TIMEOUT_CYCLES=8 with no valid_in after tail -> resp_valid=1, resp_err=1 exactly 8 cycles after entering WAIT_RESP.
REQ-038 resetn=0 during body[1] -> enable=0 next cycle, no resp_valid; new request then sends from head 0x8001.
REQ-039 valid_in=1 with 0xDEAD while IDLE, then normal transaction -> 0xDEAD never appears in resp_packet.
